// File: rtl/register_file_pkg.sv
// register_file_pkg
// Shared types and helpers for the multi-port flip-flop register file.
//   rf_state_e  : clear sequencer states (RfIdle, RfClear)
//   merge_bytes : overlays the enabled bytes of a new word onto a base word.
//                 Callers apply it in ascending port order, so the highest port
//                 index ends up owning every byte it enables.
// Words up to MaxDataWidth bits are supported. Narrower words are zero-extended
// into the helper and truncated back.
package register_file_pkg;

   typedef enum logic {
      RfIdle,
      RfClear
   } rf_state_e;

   localparam int MaxDataWidth = 64;
   localparam int MaxBytes     = MaxDataWidth / 8;

   function automatic logic [MaxDataWidth-1:0] merge_bytes(
      input logic [MaxDataWidth-1:0] base,
      input logic [MaxDataWidth-1:0] upd,
      input logic [MaxBytes-1:0]     be
   );
      logic [MaxDataWidth-1:0] res;
      res = base;
      for (int b = 0; b < MaxBytes; b++) begin
         if (be[b]) begin
            res[b*8 +: 8] = upd[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// register_file_mp_if
// Bus bundle of the multi-port register file.
//   raddr_i / rdata_o : NumRead combinational read ports
//   we_i / waddr_i / wdata_i / wbe_i : NumWrite byte-enabled write ports
//   clear_i : request a sweep of all words back to the reset value
//   busy_o  : sweep in progress, writes are refused
//   err_o   : one-cycle registered error pulse
// The master modport drives requests, and the slave modport is the register file.
interface register_file_mp_if #(
   parameter int AddrWidth = 4,
   parameter int DataWidth = 16,
   parameter int NumRead   = 2,
   parameter int NumWrite  = 2
);
   localparam int NumBytes = DataWidth / 8;

   logic [NumRead-1:0][AddrWidth-1:0]  raddr_i;
   logic [NumRead-1:0][DataWidth-1:0]  rdata_o;
   logic [NumWrite-1:0]                we_i;
   logic [NumWrite-1:0][AddrWidth-1:0] waddr_i;
   logic [NumWrite-1:0][DataWidth-1:0] wdata_i;
   logic [NumWrite-1:0][NumBytes-1:0]  wbe_i;
   logic                               clear_i;
   logic                               busy_o;
   logic                               err_o;

   modport master (
      output raddr_i, we_i, waddr_i, wdata_i, wbe_i, clear_i,
      input  rdata_o, busy_o, err_o
   );

   modport slave (
      input  raddr_i, we_i, waddr_i, wdata_i, wbe_i, clear_i,
      output rdata_o, busy_o, err_o
   );
endinterface

// File: rtl/register_file_wr_stage.sv
// register_file_wr_stage
// One stage register per write port, plus error detection.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   accept        : high when writes may be captured (sequencer idle)
//   we/waddr/wdata/wbe : raw write requests from the bus
//   stage_*       : staged entries. They feed both the commit into memory and
//                   the read bypass.
//   err           : registered pulse for an overlapping same-address write,
//                   or for a write request that is refused while busy
module register_file_wr_stage
   import register_file_pkg::*;
#(
   parameter int AddrWidth = 4,
   parameter int DataWidth = 16,
   parameter int NumWrite  = 2
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  accept,
   input  logic [NumWrite-1:0]                   we,
   input  logic [NumWrite-1:0][AddrWidth-1:0]    waddr,
   input  logic [NumWrite-1:0][DataWidth-1:0]    wdata,
   input  logic [NumWrite-1:0][DataWidth/8-1:0]  wbe,
   output logic [NumWrite-1:0]                   stage_valid,
   output logic [NumWrite-1:0][AddrWidth-1:0]    stage_addr,
   output logic [NumWrite-1:0][DataWidth-1:0]    stage_data,
   output logic [NumWrite-1:0][DataWidth/8-1:0]  stage_be,
   output logic                                  err
);

   logic [NumWrite-1:0] capture;
   logic                conflict;

   // A request with no enabled byte is ignored. It neither stages nor collides.
   always_comb begin
      capture  = '0;
      conflict = 1'b0;
      for (int p = 0; p < NumWrite; p++) begin
         capture[p] = we[p] && (|wbe[p]);
      end
      for (int i = 0; i < NumWrite; i++) begin
         for (int j = i + 1; j < NumWrite; j++) begin
            if (capture[i] && capture[j] && (waddr[i] == waddr[j]) &&
                (|(wbe[i] & wbe[j]))) begin
               conflict = 1'b1;
            end
         end
      end
   end

   // While the sweep runs, staging is emptied. Any write request is dropped,
   // and the drop is reported through err.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_valid <= '0;
         stage_addr  <= '0;
         stage_data  <= '0;
         stage_be    <= '0;
         err         <= 1'b0;
      end else begin
         err <= accept ? conflict : (|we);
         if (accept) begin
            stage_valid <= capture;
            stage_addr  <= waddr;
            stage_data  <= wdata;
            stage_be    <= wbe;
         end else begin
            stage_valid <= '0;
         end
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp
// Flip-flop based multi-port register file with staged writes and read bypass.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   bus (slave)   : read ports, byte-enabled write ports, clear request,
//                   busy and error outputs (see register_file_mp_if)
// Writes are captured on one edge and committed on the next. Reads see memory
// with any pending staged bytes laid over it. A clear request sweeps one word
// per cycle back to WordZeroVal.
module register_file_mp
   import register_file_pkg::*;
#(
   parameter int                  AddrWidth   = 4,
   parameter int                  DataWidth   = 16,
   parameter int                  NumRead     = 2,
   parameter int                  NumWrite    = 2,
   parameter bit                  ZeroReg     = 1'b1,
   parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   register_file_mp_if.slave bus
);

   localparam int NumWords = 2 ** AddrWidth;
   localparam int NumBytes = DataWidth / 8;

   logic [DataWidth-1:0] mem [NumWords];

   rf_state_e            state_q, state_d;
   logic [AddrWidth-1:0] cnt_q, cnt_d;

   logic [NumWrite-1:0]                stage_valid;
   logic [NumWrite-1:0][AddrWidth-1:0] stage_addr;
   logic [NumWrite-1:0][DataWidth-1:0] stage_data;
   logic [NumWrite-1:0][NumBytes-1:0]  stage_be;
   logic                               err;

   logic [NumRead-1:0][DataWidth-1:0]  rdata;
   logic [DataWidth-1:0]               commit_word [NumWrite];

   register_file_wr_stage #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .NumWrite  (NumWrite)
   ) u_wr_stage (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .accept      (state_q == RfIdle),
      .we          (bus.we_i),
      .waddr       (bus.waddr_i),
      .wdata       (bus.wdata_i),
      .wbe         (bus.wbe_i),
      .stage_valid (stage_valid),
      .stage_addr  (stage_addr),
      .stage_data  (stage_data),
      .stage_be    (stage_be),
      .err         (err)
   );

   // Clear sequencer. After the last word is written, the counter wraps back
   // to zero on its own.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RfIdle: begin
            if (bus.clear_i) begin
               state_d = RfClear;
               cnt_d   = '0;
            end
         end
         RfClear: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AddrWidth'(NumWords - 1)) begin
               state_d = RfIdle;
            end
         end
         default: state_d = RfIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RfIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Read ports and commit words share the same view: memory overlaid with
   // every valid stage to that address, in ascending port order. All ports
   // that stage the same address therefore commit an identical word.
   always_comb begin
      logic [DataWidth-1:0] word;
      rdata = '0;
      word  = '0;
      for (int r = 0; r < NumRead; r++) begin
         word = mem[bus.raddr_i[r]];
         for (int p = 0; p < NumWrite; p++) begin
            if (stage_valid[p] && (stage_addr[p] == bus.raddr_i[r])) begin
               word = DataWidth'(merge_bytes(MaxDataWidth'(word),
                                             MaxDataWidth'(stage_data[p]),
                                             MaxBytes'(stage_be[p])));
            end
         end
         if (ZeroReg && (bus.raddr_i[r] == '0)) begin
            word = WordZeroVal;
         end
         rdata[r] = word;
      end
      for (int q = 0; q < NumWrite; q++) begin
         word = mem[stage_addr[q]];
         for (int p = 0; p < NumWrite; p++) begin
            if (stage_valid[p] && (stage_addr[p] == stage_addr[q])) begin
               word = DataWidth'(merge_bytes(MaxDataWidth'(word),
                                             MaxDataWidth'(stage_data[p]),
                                             MaxBytes'(stage_be[p])));
            end
         end
         commit_word[q] = word;
      end
   end

   // Storage. The clear write comes last, so it wins over a commit to the
   // same word on the same edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int w = 0; w < NumWords; w++) begin
            mem[w] <= WordZeroVal;
         end
      end else begin
         for (int p = 0; p < NumWrite; p++) begin
            if (stage_valid[p] && !(ZeroReg && (stage_addr[p] == '0))) begin
               mem[stage_addr[p]] <= commit_word[p];
            end
         end
         if (state_q == RfClear) begin
            mem[cnt_q] <= WordZeroVal;
         end
      end
   end

   assign bus.rdata_o = rdata;
   assign bus.busy_o  = (state_q == RfClear);
   assign bus.err_o   = err;

endmodule
